// File: rtl/register_file.sv
// register_file
//   32 x 32-bit general-purpose register file for the single-cycle MIPS
//   datapath. Two combinational read ports, one write port that commits
//   on the falling edge of clk. Register $0 has no storage and reads 0.
//
// Ports
//   clk    in   clock; writes commit on the falling edge
//   rst_n  in   asynchronous active-low reset, clears every register
//   Ra     in   read address, port A
//   Rb     in   read address, port B
//   Rw     in   write address
//   Bw     in   write data
//   Regwr  in   write enable, active high
//   Ba     out  reg[Ra], combinational
//   Bb     out  reg[Rb], combinational
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a pending write (Regwr=1, Rw!=0) is
//                      forwarded from Bw to any read port addressing Rw
//                      before the edge. Undefined by default.

module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] Ra,
   input  logic [ADDR_WIDTH-1:0] Rb,
   input  logic [ADDR_WIDTH-1:0] Rw,
   input  logic [DATA_WIDTH-1:0] Bw,
   input  logic                  Regwr,
   output logic [DATA_WIDTH-1:0] Ba,
   output logic [DATA_WIDTH-1:0] Bb
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   // Entry 0 is deliberately absent; the read path substitutes zero.
   logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

   logic wr_active;

   assign wr_active = Regwr && (Rw != '0);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else if (wr_active) begin
         regs[Rw] <= Bw;
      end
   end

   always_comb begin
      Ba = '0;
      Bb = '0;
      if (Ra != '0) begin
         Ba = regs[Ra];
      end
      if (Rb != '0) begin
         Bb = regs[Rb];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight write data; wr_active already excludes $0.
      if (wr_active && (Ra == Rw)) begin
         Ba = Bw;
      end
      if (wr_active && (Rb == Rw)) begin
         Bb = Bw;
      end
`endif
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed plus randomized checks of register_file against a simple
//   array model of the register contents. Inputs are driven while clk is
//   high (after the rising edge); outputs are sampled 1 time unit after
//   input changes or after the falling (write) edge.

module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  Ra;
   logic [4:0]  Rb;
   logic [4:0]  Rw;
   logic [31:0] Bw;
   logic        Regwr;
   logic [31:0] Ba;
   logic [31:0] Bb;

   int unsigned vectors;
   int unsigned miscompares;

   // Reference contents; index 0 is never consulted.
   logic [31:0] model [32];

   register_file #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Ra    (Ra),
      .Rb    (Rb),
      .Rw    (Rw),
      .Bw    (Bw),
      .Regwr (Regwr),
      .Ba    (Ba),
      .Bb    (Bb)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] observed,
                      input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Expected read value. 'pre' means before the falling edge, when a
   // pending write may be forwarded in the bypass build.
   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit pre);
      logic [31:0] v;
      v = (a == 5'd0) ? 32'd0 : model[a];
`ifdef REGFILE_BYPASS_EN
      if (pre && Regwr && (Rw != 5'd0) && (a == Rw)) v = Bw;
`else
      if (pre) v = v;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   task automatic model_edge();
      if (rst_n && Regwr && (Rw != 5'd0)) model[Rw] = Bw;
   endtask

   // One write cycle: drive after rising edge, commit on falling edge.
   task automatic do_write(input logic [4:0] w, input logic [31:0] d,
                           input logic en);
      @(posedge clk);
      #1;
      Rw = w;
      Bw = d;
      Regwr = en;
      @(negedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      logic [5:0]  wide;
      logic [31:0] bcd;

      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      Ra = 5'd0;
      Rb = 5'd0;
      Rw = 5'd0;
      Bw = 32'd0;
      Regwr = 1'b0;
      model_reset();

      // Reset state: everything reads zero while reset is held.
      #2;
      chk("reset_a0", Ba, 32'd0);
      chk("reset_b0", Bb, 32'd0);
      Ra = 5'd7;
      Rb = 5'd31;
      #1;
      chk("reset_a7", Ba, 32'd0);
      chk("reset_b31", Bb, 32'd0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      Ra = 5'd0;
      Rb = 5'd0;

      // Writes to $0 are discarded.
      do_write(5'd0, 32'h1234_5678, 1'b1);
      chk("r0_write_a", Ba, 32'd0);
      chk("r0_write_b", Bb, 32'd0);

      // Fill 1..31 with BCD-style values.
      for (int n = 1; n < 32; n++) begin
         bcd = 32'((n / 10) * 16 + (n % 10));
         do_write(5'(n), bcd, 1'b1);
      end
      @(posedge clk);
      #1;
      Regwr = 1'b0;
      for (int n = 1; n < 32; n += 2) begin
         Ra = 5'(n);
         Rb = (n == 31) ? 5'd31 : 5'(n + 1);
         #1;
         chk("fill_a", Ba, 32'((n / 10) * 16 + (n % 10)));
         chk("fill_b", Bb, exp_rd(Rb, 1'b0));
      end
      chk("fill_b31", Bb, 32'h31);

      // Overwrite reg1 while both ports watch.
      @(posedge clk);
      #1;
      Ra = 5'd1;
      Rb = 5'd2;
      Rw = 5'd1;
      Bw = 32'h1234_5678;
      Regwr = 1'b1;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("ovw_pre_a", Ba, 32'h1234_5678);
`else
      chk("ovw_pre_a", Ba, 32'h1);
`endif
      chk("ovw_pre_b", Bb, 32'h2);
      @(negedge clk);
      model_edge();
      #1;
      chk("ovw_post_a", Ba, 32'h1234_5678);
      chk("ovw_post_b", Bb, 32'h2);

      // Write disabled.
      do_write(5'd3, 32'h1234_5678, 1'b0);
      Ra = 5'd3;
      #1;
      chk("wr_dis", Ba, 32'h3);

      // Address truncation: 32 wraps to 0.
      wide = 6'd32;
      Ra = wide[4:0];
      #1;
      chk("trunc", Ba, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         Ra = 5'($urandom_range(31));
         Rb = ($urandom_range(3) == 0) ? Ra : 5'($urandom_range(31));
         Rw = ($urandom_range(3) == 0) ? Ra : 5'($urandom_range(31));
         Bw = $urandom;
         Regwr = 1'($urandom_range(1));
         #1;
         chk("rnd_pre_a", Ba, exp_rd(Ra, 1'b1));
         chk("rnd_pre_b", Bb, exp_rd(Rb, 1'b1));
         @(negedge clk);
         model_edge();
         #1;
         chk("rnd_post_a", Ba, exp_rd(Ra, 1'b0));
         chk("rnd_post_b", Bb, exp_rd(Rb, 1'b0));
      end

      // Asynchronous reset with no clock edge: all addresses read zero.
      @(posedge clk);
      #1;
      Regwr = 1'b0;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 32; i++) begin
         Ra = 5'(i);
         Rb = 5'(31 - i);
         #0.1;
         chk("areset_a", Ba, 32'd0);
         chk("areset_b", Bb, 32'd0);
      end

      // Write attempted under reset is lost.
      do_write(5'd5, 32'hA5, 1'b1);
      @(posedge clk);
      #1;
      Regwr = 1'b0;
      rst_n = 1'b1;
      Ra = 5'd5;
      Rb = 5'd5;
      #1;
      chk("rst_wr_a", Ba, 32'd0);
      chk("rst_wr_b", Bb, 32'd0);

      // First falling edge after release performs a write.
      do_write(5'd5, 32'hA5, 1'b1);
      chk("post_rel_a", Ba, 32'hA5);
      chk("post_rel_b", Bb, exp_rd(5'd5, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
